bank_group_arbiter: RTL and testbench

- Second-level arbiter directly downstream of the per-bank-group drain FSMs.
- Each bank-group FSM raises `req[g]` while any of its banks holds a valid entry. It drains only while its `start[g]` is high, and pulses `done[g]` when its burst ends.
- This block grants exactly one bank group at a time, in round-robin order, and drives the registered one-hot `start` vector plus the index used to steer the shared command/data mux.

---
 rtl/arbiter_pkg.sv | 6 +
 rtl/rr_priority_picker.sv | 18 +
 rtl/bank_group_arbiter.sv | 95 +++++++++
 tb/tb_bank_group_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared state encoding and default sizing for the bank-group arbiter.
package arbiter_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, TURN} bg_arb_state_t;
    localparam int BG_NUM_GROUPS = 4;
    localparam int BG_TIMEOUT_CYCLES = 32;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester after `last`, with wrap.
module rr_priority_picker #(
    parameter int N = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);
    always_comb begin
        pick = last;
        // Scan from lowest to highest priority so the nearest requester after last is kept.
        for (int i = N; i >= 1; i--)
            if (req[IDX_W'(int'(last) + i)]) pick = IDX_W'(int'(last) + i);
    end
    assign any = |req;
endmodule

// File: rtl/bank_group_arbiter.sv
// bank_group_arbiter: round-robin grant of one bank-group drain FSM at a time, with a turnaround cycle.
// BANK_GROUP_ARB_TIMEOUT_EN enables revoking a grant held for TIMEOUT_CYCLES while others wait.
module bank_group_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_GROUPS = BG_NUM_GROUPS,
    parameter int TIMEOUT_CYCLES = BG_TIMEOUT_CYCLES,
    parameter int IDX_W = $clog2(NUM_GROUPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_GROUPS-1:0] req,
    input  logic [NUM_GROUPS-1:0] done,
    output logic [NUM_GROUPS-1:0] start,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic                  preempt
);
    if (NUM_GROUPS != (1 << IDX_W) || NUM_GROUPS < 2 || NUM_GROUPS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("bank_group_arbiter: unsupported NUM_GROUPS/TIMEOUT_CYCLES");
    end

    bg_arb_state_t state, state_n;
    logic [NUM_GROUPS-1:0] start_n;
    logic [IDX_W-1:0] grant_idx_n, last_grant, last_grant_n, pick;
    logic any, granted_done, timeout;

    rr_priority_picker #(.N(NUM_GROUPS), .IDX_W(IDX_W)) u_picker (
        .req(req),
        .last(last_grant),
        .pick(pick),
        .any(any)
    );

    assign granted_done = done[grant_idx];
    assign grant_valid = |start;

`ifdef BANK_GROUP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] count, count_n;
    // start is one-hot on the holder during GRANT, so masking it leaves only the waiting groups.
    assign timeout = count == CNT_W'(TIMEOUT_CYCLES) && |(req & ~start);
    always_comb begin
        count_n = count;
        if (state == IDLE) count_n = '0;
        else if (state == GRANT && count != CNT_W'(TIMEOUT_CYCLES)) count_n = count + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            preempt <= 1'b0;
        end else begin
            count <= count_n;
            preempt <= state == GRANT && timeout && !granted_done;
        end
    end
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n = state;
        start_n = start;
        grant_idx_n = grant_idx;
        last_grant_n = last_grant;
        case (state)
            IDLE: if (any) begin
                state_n = GRANT;
                start_n = NUM_GROUPS'(1) << pick;
                grant_idx_n = pick;
                last_grant_n = pick;
            end
            GRANT: if (granted_done || timeout) begin
                state_n = TURN;
                start_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            start <= '0;
            grant_idx <= '0;
            last_grant <= IDX_W'(NUM_GROUPS - 1);
        end else begin
            state <= state_n;
            start <= start_n;
            grant_idx <= grant_idx_n;
            last_grant <= last_grant_n;
        end
    end
endmodule

// File: tb/tb_bank_group_arbiter.sv
// tb_bank_group_arbiter: directed and randomized checks of bank_group_arbiter against a grant-level model.
module tb_bank_group_arbiter;
    localparam int N = 4;
    localparam int T = 32;
`ifdef BANK_GROUP_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] start;
    logic [1:0] grant_idx;
    logic grant_valid, preempt;

    int n_checks = 0;
    int n_fail = 0;

    // Model: who holds the grant (-1 none), forced idle cycles left, last winner, shown index, cycles held.
    int holder = -1;
    int wait_c = 0;
    int last = N - 1;
    int gidx = 0;
    int held = 0;
    bit pre = 1'b0;

    bank_group_arbiter dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .start(start),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] onehot(input int g);
        return (g >= 0) ? (N'(1) << g) : '0;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        int nh, nw, nl, ng, nk;
        bit np, to;
        req = r;
        done = d;
        rst = rs;
        nh = holder; nw = wait_c; nl = last; ng = gidx; nk = held; np = 1'b0;
        if (rs) begin
            nh = -1; nw = 0; nl = N - 1; ng = 0; nk = 0;
        end else if (holder >= 0) begin
            to = TO_EN && held >= T && (r & ~onehot(holder)) != '0;
            if (d[holder] || to) begin
                nh = -1; nw = 1; np = !d[holder];
            end else nk = held + 1;
        end else if (wait_c > 0) begin
            nw = wait_c - 1;
        end else begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (last + i) % N;
                if (r[c]) begin
                    nh = c; nl = c; ng = c; nk = 0;
                    break;
                end
            end
        end
        @(posedge clk);
        holder = nh; wait_c = nw; last = nl; gidx = ng; held = nk; pre = np;
        @(negedge clk);
    endtask

    task automatic do_reset();
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
    endtask

    task automatic test_reset();
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        n_checks++;
        if (start !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: start=%b idx=%0d valid=%b preempt=%b required 0000/0/0/0",
                     start, grant_idx, grant_valid, preempt);
        end
        step('0, '0, 1'b0);
    endtask

    task automatic test_single();
        do_reset();
        step(4'b0100, '0, 1'b0);
        n_checks++;
        if (start !== 4'b0100 || grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: start=%b idx=%0d valid=%b required 0100/2/1", start, grant_idx, grant_valid);
        end
        step(4'b0100, 4'b0001, 1'b0);
        n_checks++;
        if (start !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_foreign_done: start=%b required 0100", start);
        end
        step(4'b0000, 4'b0100, 1'b0);
        n_checks++;
        if (start !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_release: start=%b valid=%b idx=%0d required 0000/0/2", start, grant_valid, grant_idx);
        end
        step(4'b0000, '0, 1'b0);
        n_checks++;
        if (start !== 4'b0000 || grant_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL single_turn: start=%b idx=%0d required 0000/2", start, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        int n, idle;
        bit pv;
        logic [1:0] order [5];
        int gaps [5];
        do_reset();
        n = 0; idle = 0; pv = 1'b0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            step(4'b1111, (holder >= 0 && held == 3) ? onehot(holder) : '0, 1'b0);
            if (grant_valid && !pv) begin
                order[n] = grant_idx;
                gaps[n] = idle;
                n++;
            end
            idle = grant_valid ? 0 : idle + 1;
            pv = grant_valid;
        end
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d grants, required 5", n);
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (order[i] !== 2'(i % N) || (i > 0 && gaps[i] != 2)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: idx=%0d gap=%0d required idx=%0d gap=2", i, order[i], gaps[i], i % N);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(4'b0100, '0, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        step(4'b1001, '0, 1'b0);
        step(4'b1001, '0, 1'b0);
        n_checks++;
        if (start !== 4'b1000 || grant_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_first: start=%b idx=%0d required 1000/3", start, grant_idx);
        end
        step(4'b1001, 4'b1000, 1'b0);
        step(4'b1001, '0, 1'b0);
        step(4'b1001, '0, 1'b0);
        n_checks++;
        if (start !== 4'b0001 || grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_next: start=%b idx=%0d required 0001/0", start, grant_idx);
        end
    endtask

`ifdef BANK_GROUP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int held0, pcount;
        bit pre_ok;
        do_reset();
        held0 = 0; pcount = 0; pre_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step(4'b0011, '0, 1'b0);
            if (start === 4'b0001) held0++;
            if (preempt === 1'b1) begin
                pcount++;
                if (start !== 4'b0000) pre_ok = 1'b0;
            end
        end
        n_checks++;
        if (held0 != T + 1 || pcount != 1 || !pre_ok || start !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout: held=%0d preempts=%0d pre_ok=%b start=%b required %0d/1/1/0010",
                     held0, pcount, pre_ok, start, T + 1);
        end
    endtask

    task automatic test_timeout_done();
        do_reset();
        step(4'b0011, '0, 1'b0);
        for (int c = 0; c < 2 * T && held < T; c++) step(4'b0011, '0, 1'b0);
        step(4'b0011, 4'b0001, 1'b0);
        n_checks++;
        if (preempt !== 1'b0 || start !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_vs_done: preempt=%b start=%b required 0/0000", preempt, start);
        end
        step(4'b0011, '0, 1'b0);
        step(4'b0011, '0, 1'b0);
        n_checks++;
        if (start !== 4'b0010) begin
            n_fail++;
            $display("FAIL timeout_vs_done_next: start=%b required 0010", start);
        end
    endtask
`else
    task automatic test_hold();
        int held0, pcount;
        do_reset();
        held0 = 0; pcount = 0;
        for (int c = 0; c < 60; c++) begin
            step(4'b0011, '0, 1'b0);
            if (start === 4'b0001) held0++;
            if (preempt !== 1'b0) pcount++;
        end
        n_checks++;
        if (held0 != 60 || pcount != 0) begin
            n_fail++;
            $display("FAIL hold: held=%0d preempt_cycles=%0d required 60/0", held0, pcount);
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        step(4'b0001, '0, 1'b0);
        step(4'b0001, '0, 1'b0);
        step(4'b0001, '0, 1'b1);
        n_checks++;
        if (start !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0 || preempt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: start=%b valid=%b idx=%0d preempt=%b required 0000/0/0/0",
                     start, grant_valid, grant_idx, preempt);
        end
        step(4'b0010, '0, 1'b0);
        n_checks++;
        if (start !== 4'b0010 || grant_idx !== 2'd1 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_regrant: start=%b idx=%0d valid=%b required 0010/1/1", start, grant_idx, grant_valid);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r, d;
        logic rs;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            r = N'($urandom);
            d = N'($urandom) & ~onehot(holder);
            if (holder >= 0 && $urandom_range(0, 3) == 0) d = d | onehot(holder);
            rs = $urandom_range(0, 199) == 0;
            step(r, d, rs);
            n_checks++;
            if (start !== onehot(holder) || grant_idx !== 2'(gidx) || grant_valid !== (holder >= 0) || preempt !== pre) begin
                n_fail++;
                $display("FAIL random cyc %0d: start=%b idx=%0d valid=%b preempt=%b required %b/%0d/%b/%b",
                         c, start, grant_idx, grant_valid, preempt, onehot(holder), gidx, holder >= 0, pre);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
`ifdef BANK_GROUP_ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_done();
`else
        test_hold();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
